calendar_counter: RTL and testbench
===================================

Name: calendar_counter

Overview:
- Timekeeping source for the clock: holds year/month/day/hour/minute/second/weekday and advances them on a 1 Hz tick from the divider.
- Feeds the display formatter and the alarm comparator, which consume the time fields directly.
- Accepts a one-cycle validated load from the time-setting UI.
- Drives rollover strobes for the chime/alarm logic.

Parameters:
- RST_YEAR, 2024, year value at reset
- RST_MONTH, 1, month value at reset (1..12)
- RST_DAY, 1, day value at reset (1..31)
- RST_WEEK, 1, weekday at reset (0=Sun..6=Sat); 2024-01-01 is Monday
- YEAR_MIN, 2000, year value after wrap
- YEAR_MAX, 2099, last valid year; the year after it wraps to YEAR_MIN

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active low
- tick_1hz  in  1  one-cycle pulse from the divider, at most one per second
- load  in  1  one-cycle request to overwrite all fields
- ld_year  in  16  load value for year
- ld_month  in  6  load value for month
- ld_day  in  11  load value for day
- ld_hour  in  11  load value for hour
- ld_minute  in  11  load value for minute
- ld_second  in  11  load value for second
- ld_week  in  11  load value for weekday
- year  out  16  current year
- month  out  6  current month
- day  out  11  current day
- hour  out  11  current hour
- minute  out  11  current minute
- second  out  11  current second
- week  out  11  current weekday
- min_wrap  out  1  one-cycle strobe when second wraps 59->0
- hour_wrap  out  1  one-cycle strobe when minute wraps 59->0
- day_wrap  out  1  one-cycle strobe when hour wraps 23->0
- load_err  out  1  one-cycle strobe when a load is rejected

Behaviour:
- Clocking and reset:
  - One clock domain (clk). Reset is synchronous and active-low (rst_n); all state updates on posedge clk.
  - While rst_n=0 the outputs take these values: year=RST_YEAR, month=RST_MONTH, day=RST_DAY, hour=minute=second=0, week=RST_WEEK, and all strobes are 0.
  - Reset has priority over everything else. Asserting it mid-operation discards any in-flight load or tick in that cycle.
- Tick advance:
  - tick_1hz sampled high at edge N updates the outputs at edge N, so they are visible the cycle after the tick. Latency is 1 cycle.
  - second increments. At 59 it becomes 0 and minute increments, and min_wrap=1 for that cycle.
  - minute 59->0 carries into hour and asserts hour_wrap.
  - hour 23->0 carries into day and asserts day_wrap.
  - On every day carry, week advances mod 7 (6->0).
  - When day equals days_in_month(month, year), day becomes 1 and month increments. Month 12->1 increments year.
  - Year at YEAR_MAX wraps to YEAR_MIN.
  - A full cascade happens in one cycle: 12-31 23:59:59 + tick gives 01-01 00:00:00 of the next year, with all three wrap strobes high together.
  - Strobes are registered, high exactly one cycle, and coincide with the updated field values.
- Load:
  - Valid only if all of the following hold:
    - month in 1..12
    - day in 1..days_in_month(ld_month, ld_year)
    - hour<=23, minute<=59, second<=59
    - week<=6
    - ld_year in YEAR_MIN..YEAR_MAX
  - A valid load writes all fields at that edge, with no strobes.
  - An invalid load leaves all fields unchanged and pulses load_err for one cycle.
  - If load and tick_1hz arrive in the same cycle, the load wins (valid or not) and the tick is dropped, with no strobes.
- State: a single running state. There is no FSM beyond the carry chain.
- Arithmetic: compares are done at full port width. Upper unused bits of fields are always 0.

Optional Feature:
- Macro: CAL_LEAP_EN.
- Defined: February has 29 days when the year is divisible by 4 and not by 100, or is divisible by 400. Applies to both the advance and the load validation.
- Undefined: February is always 28 days, and a load of 02-29 raises load_err.

Decomposition:
- Shared package/header cal_pkg holds:
  - constants SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23, WEEK_MAX=6, MONTH_MAX=12
  - the 12-entry days-per-month table
  - weekday encodings SUN..SAT
- One natural sub-module, cal_days_in_month: combinational, takes (month, year) and returns 28..31, with the leap logic under CAL_LEAP_EN. It is instantiated twice, once for the current date and once for the load fields.

Test Plan:
- Reset default: hold rst_n=0 for 3 cycles, then release -> outputs 2024-01-01 00:00:00, week=1, all strobes 0.
- Minute/hour cascade: load 2024-03-10 10:59:59, then tick -> 11:00:00, with min_wrap=1, hour_wrap=1, day_wrap=0 for exactly 1 cycle.
- Year rollover: load 2024-12-31 23:59:59 week=2, then tick -> 2025-01-01 00:00:00, week=3, all three strobes high together.
- Leap handling:
  - With CAL_LEAP_EN: load 2024-02-28 23:59:59, then tick -> 02-29.
  - With CAL_LEAP_EN: load 2100-... is outside YEAR_MAX and rejected (load_err=1). Also check that 2000-02-29 is accepted.
  - Without CAL_LEAP_EN: load 2024-02-29 -> load_err=1 and the fields are unchanged.
- Invalid load: ld_month=13 or ld_hour=24 -> load_err pulses 1 cycle and the previous values are retained.
- Collision: load 2024-05-05 12:00:00 together with tick_1hz in the same cycle -> second=0 (tick dropped), no strobes. Also assert rst_n=0 together with load and check the reset values win.

Source files
------------

// File: rtl/cal_pkg.sv
// Shared constants for the calendar counter: field limits, weekday
// encodings and the days-per-month table used by the month-length lookup.
package cal_pkg;

    typedef enum logic [2:0] {
        SUN = 3'd0,
        MON = 3'd1,
        TUE = 3'd2,
        WED = 3'd3,
        THU = 3'd4,
        FRI = 3'd5,
        SAT = 3'd6
    } weekday_e;

    localparam logic [10:0] SEC_MAX   = 11'd59;
    localparam logic [10:0] MIN_MAX   = 11'd59;
    localparam logic [10:0] HOUR_MAX  = 11'd23;
    localparam logic [10:0] WEEK_MAX  = 11'(SAT);
    localparam logic [5:0]  MONTH_MAX = 6'd12;
    localparam logic [5:0]  FEB       = 6'd2;

    // Non-leap month lengths, indexed by month number 1..12.
    localparam logic [4:0] DAYS_TBL [1:12] = '{
        5'd31, 5'd28, 5'd31, 5'd30, 5'd31, 5'd30,
        5'd31, 5'd31, 5'd30, 5'd31, 5'd30, 5'd31
    };

endpackage

// File: rtl/cal_days_in_month.sv
// Combinational month-length lookup: returns 28..31 for (month, year).
// Build option: define CAL_LEAP_EN to give February 29 days in leap years
// (divisible by 4 and not by 100, or divisible by 400). Without it February
// is always 28 days. Out-of-range months return 31; callers range-check the
// month themselves.
module cal_days_in_month
    import cal_pkg::*;
(
    input  logic [5:0]  month,
    input  logic [15:0] year,
    output logic [10:0] days
);

    logic leap_en;
    logic is_leap;

`ifdef CAL_LEAP_EN
    assign leap_en = 1'b1;
`else
    assign leap_en = 1'b0;
`endif

    assign is_leap = (((year % 16'd4) == 16'd0) && ((year % 16'd100) != 16'd0))
                   || ((year % 16'd400) == 16'd0);

    // Table lookup with the February leap override on top.
    always_comb begin
        days = 11'd31;
        if (month >= 6'd1 && month <= MONTH_MAX) begin
            days = {6'd0, DAYS_TBL[month[3:0]]};
        end
        if (month == FEB && is_leap && leap_en) begin
            days = 11'd29;
        end
    end

endmodule

// File: rtl/calendar_counter.sv
// Calendar/time-of-day counter advanced by a 1 Hz tick, with a validated
// one-cycle load and registered rollover strobes.
// Build option: CAL_LEAP_EN enables leap-year February (see cal_days_in_month).
//
// Control semantics: tick_1hz and load are single-cycle pulses sampled at
// posedge clk with no backpressure. Load has priority over tick in the same
// cycle (the tick is dropped); rst_n low has priority over both. Strobes
// are high for exactly the cycle in which the updated fields are visible.
module calendar_counter
    import cal_pkg::*;
#(
    parameter int RST_YEAR  = 2024,
    parameter int RST_MONTH = 1,
    parameter int RST_DAY   = 1,
    parameter int RST_WEEK  = 1,
    parameter int YEAR_MIN  = 2000,
    parameter int YEAR_MAX  = 2099
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick_1hz,
    input  logic        load,
    input  logic [15:0] ld_year,
    input  logic [5:0]  ld_month,
    input  logic [10:0] ld_day,
    input  logic [10:0] ld_hour,
    input  logic [10:0] ld_minute,
    input  logic [10:0] ld_second,
    input  logic [10:0] ld_week,
    output logic [15:0] year,
    output logic [5:0]  month,
    output logic [10:0] day,
    output logic [10:0] hour,
    output logic [10:0] minute,
    output logic [10:0] second,
    output logic [10:0] week,
    output logic        min_wrap,
    output logic        hour_wrap,
    output logic        day_wrap,
    output logic        load_err
);

    localparam logic [15:0] Y_MIN = 16'(YEAR_MIN);
    localparam logic [15:0] Y_MAX = 16'(YEAR_MAX);

    logic [10:0] cur_dim;
    logic [10:0] ld_dim;
    logic        load_ok;
    logic        sec_carry;
    logic        min_carry;
    logic        day_carry;
    logic        mon_carry;
    logic        yr_carry;

    // Month length of the running date and of the date being loaded.
    cal_days_in_month u_cur_dim (
        .month (month),
        .year  (year),
        .days  (cur_dim)
    );

    cal_days_in_month u_ld_dim (
        .month (ld_month),
        .year  (ld_year),
        .days  (ld_dim)
    );

    assign load_ok = (ld_month >= 6'd1) && (ld_month <= MONTH_MAX)
                  && (ld_day >= 11'd1) && (ld_day <= ld_dim)
                  && (ld_hour <= HOUR_MAX)
                  && (ld_minute <= MIN_MAX)
                  && (ld_second <= SEC_MAX)
                  && (ld_week <= WEEK_MAX)
                  && (ld_year >= Y_MIN) && (ld_year <= Y_MAX);

    // Carry chain: each stage only carries when every lower stage wraps.
    assign sec_carry = (second == SEC_MAX);
    assign min_carry = sec_carry && (minute == MIN_MAX);
    assign day_carry = min_carry && (hour == HOUR_MAX);
    assign mon_carry = day_carry && (day == cur_dim);
    assign yr_carry  = mon_carry && (month == MONTH_MAX);

    // Field registers and strobes: reset, then load, then tick advance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            year      <= 16'(RST_YEAR);
            month     <= 6'(RST_MONTH);
            day       <= 11'(RST_DAY);
            hour      <= 11'd0;
            minute    <= 11'd0;
            second    <= 11'd0;
            week      <= 11'(RST_WEEK);
            min_wrap  <= 1'b0;
            hour_wrap <= 1'b0;
            day_wrap  <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            min_wrap  <= 1'b0;
            hour_wrap <= 1'b0;
            day_wrap  <= 1'b0;
            load_err  <= 1'b0;
            if (load) begin
                if (load_ok) begin
                    year   <= ld_year;
                    month  <= ld_month;
                    day    <= ld_day;
                    hour   <= ld_hour;
                    minute <= ld_minute;
                    second <= ld_second;
                    week   <= ld_week;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (tick_1hz) begin
                second   <= sec_carry ? 11'd0 : second + 11'd1;
                min_wrap <= sec_carry;
                if (sec_carry) begin
                    minute    <= min_carry ? 11'd0 : minute + 11'd1;
                    hour_wrap <= min_carry;
                end
                if (min_carry) begin
                    hour     <= day_carry ? 11'd0 : hour + 11'd1;
                    day_wrap <= day_carry;
                end
                if (day_carry) begin
                    week <= (week == WEEK_MAX) ? 11'(SUN) : week + 11'd1;
                    day  <= mon_carry ? 11'd1 : day + 11'd1;
                end
                if (mon_carry) begin
                    month <= yr_carry ? 6'd1 : month + 6'd1;
                end
                if (yr_carry) begin
                    year <= (year == Y_MAX) ? Y_MIN : year + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_calendar_counter.sv
// Bench for calendar_counter. The reference model keeps the time of day as
// seconds-since-midnight and the date as plain integers, and predicts every
// output (fields and strobes) each cycle into exp_q.
module tb_calendar_counter;

    localparam int RST_YEAR  = 2024;
    localparam int RST_MONTH = 1;
    localparam int RST_DAY   = 1;
    localparam int RST_WEEK  = 1;
    localparam int YEAR_MIN  = 2000;
    localparam int YEAR_MAX  = 2099;
    localparam int W = 81;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick_1hz = 1'b0;
    logic        load = 1'b0;
    logic [15:0] ld_year = '0;
    logic [5:0]  ld_month = '0;
    logic [10:0] ld_day = '0, ld_hour = '0, ld_minute = '0, ld_second = '0, ld_week = '0;
    logic [15:0] year;
    logic [5:0]  month;
    logic [10:0] day, hour, minute, second, week;
    logic        min_wrap, hour_wrap, day_wrap, load_err;

    always #5 clk = ~clk;

    calendar_counter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_1hz  (tick_1hz),
        .load      (load),
        .ld_year   (ld_year),
        .ld_month  (ld_month),
        .ld_day    (ld_day),
        .ld_hour   (ld_hour),
        .ld_minute (ld_minute),
        .ld_second (ld_second),
        .ld_week   (ld_week),
        .year      (year),
        .month     (month),
        .day       (day),
        .hour      (hour),
        .minute    (minute),
        .second    (second),
        .week      (week),
        .min_wrap  (min_wrap),
        .hour_wrap (hour_wrap),
        .day_wrap  (day_wrap),
        .load_err  (load_err)
    );

    // ---------------- reference model ----------------
    int e_year, e_month, e_day, e_hour, e_minute, e_second, e_week;
    bit e_minw, e_hourw, e_dayw, e_err;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_v;
    int vectors = 0;
    int miscompares = 0;

    function automatic int days_in(input int m, input int y);
        case (m)
            4, 6, 9, 11: return 30;
            2: begin
`ifdef CAL_LEAP_EN
                if ((y % 4 == 0 && y % 100 != 0) || (y % 400 == 0)) return 29;
`endif
                return 28;
            end
            default: return 31;
        endcase
    endfunction

    function automatic bit load_valid(input int y, input int mo, input int d, input int h,
                                      input int mi, input int s, input int w);
        if (mo < 1 || mo > 12) return 0;
        if (y < YEAR_MIN || y > YEAR_MAX) return 0;
        if (d < 1 || d > days_in(mo, y)) return 0;
        return (h <= 23) && (mi <= 59) && (s <= 59) && (w <= 6);
    endfunction

    task automatic model_tick();
        int tod;
        tod = e_hour * 3600 + e_minute * 60 + e_second + 1;
        e_dayw = (tod == 86400);
        if (e_dayw) begin
            tod = 0;
            e_week = (e_week + 1) % 7;
            if (e_day < days_in(e_month, e_year)) e_day++;
            else begin
                e_day = 1;
                if (e_month == 12) begin
                    e_month = 1;
                    e_year = (e_year == YEAR_MAX) ? YEAR_MIN : e_year + 1;
                end else e_month++;
            end
        end
        e_second = tod % 60;
        e_minute = (tod / 60) % 60;
        e_hour   = tod / 3600;
        e_minw   = (tod % 60 == 0);
        e_hourw  = (tod % 3600 == 0);
    endtask

    function automatic logic [W-1:0] model_vec();
        return {16'(e_year), 6'(e_month), 11'(e_day), 11'(e_hour), 11'(e_minute),
                11'(e_second), 11'(e_week), e_minw, e_hourw, e_dayw, e_err};
    endfunction

    function automatic logic [W-1:0] dut_vec();
        return {year, month, day, hour, minute, second, week,
                min_wrap, hour_wrap, day_wrap, load_err};
    endfunction

    // ---------------- driver ----------------
    // Drives one cycle of inputs, advances the model, queues the prediction.
    task automatic drive_cycle(input bit r, input bit ld, input bit tk,
                               input int y, input int mo, input int d, input int h,
                               input int mi, input int s, input int w);
        rst_n = !r; load = ld; tick_1hz = tk;
        ld_year = 16'(y); ld_month = 6'(mo); ld_day = 11'(d); ld_hour = 11'(h);
        ld_minute = 11'(mi); ld_second = 11'(s); ld_week = 11'(w);
        @(posedge clk);
        #1;
        rst_n = 1'b1; load = 1'b0; tick_1hz = 1'b0;
        e_minw = 0; e_hourw = 0; e_dayw = 0; e_err = 0;
        if (r) begin
            e_year = RST_YEAR; e_month = RST_MONTH; e_day = RST_DAY;
            e_hour = 0; e_minute = 0; e_second = 0; e_week = RST_WEEK;
        end else if (ld) begin
            if (load_valid(y, mo, d, h, mi, s, w)) begin
                e_year = y; e_month = mo; e_day = d; e_hour = h;
                e_minute = mi; e_second = s; e_week = w;
            end else e_err = 1;
        end else if (tk) begin
            model_tick();
        end
        exp_q.push_back(model_vec());
    endtask

    task automatic idle_cycle();
        drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick_cycle();
        drive_cycle(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            exp_v = exp_q.pop_front(); vectors++;
            if (dut_vec() !== exp_v) begin
                miscompares++;
                $display("FAIL reset_hold[%0d]: got %h expected %h", i, dut_vec(), exp_v);
            end
        end
        idle_cycle();
        exp_v = exp_q.pop_front(); vectors++;
        if (dut_vec() !== exp_v) begin
            miscompares++;
            $display("FAIL reset_release: got %h expected %h", dut_vec(), exp_v);
        end
    endtask

    task automatic test_cascade();
        drive_cycle(0, 1, 0, 2024, 3, 10, 10, 59, 59, 0);
        tick_cycle();
        idle_cycle();
        for (int i = 0; i < 3; i++) begin
            // compare after each of load, tick, idle in order
        end
        // The queue holds three predictions; DUT only shows the latest, so
        // re-run the sequence comparing cycle by cycle.
        exp_q.delete();
        drive_cycle(0, 1, 0, 2024, 3, 10, 10, 59, 59, 0);
        exp_v = exp_q.pop_front(); vectors++;
        if (dut_vec() !== exp_v) begin
            miscompares++;
            $display("FAIL cascade_load: got %h expected %h", dut_vec(), exp_v);
        end
        tick_cycle();
        exp_v = exp_q.pop_front(); vectors++;
        if (dut_vec() !== exp_v) begin
            miscompares++;
            $display("FAIL cascade_tick: got %h expected %h", dut_vec(), exp_v);
        end
        idle_cycle();
        exp_v = exp_q.pop_front(); vectors++;
        if (dut_vec() !== exp_v) begin
            miscompares++;
            $display("FAIL cascade_strobe_drop: got %h expected %h", dut_vec(), exp_v);
        end
    endtask

    task automatic test_year_rollover();
        drive_cycle(0, 1, 0, 2024, 12, 31, 23, 59, 59, 2);
        exp_v = exp_q.pop_front(); vectors++;
        if (dut_vec() !== exp_v) begin
            miscompares++;
            $display("FAIL rollover_load: got %h expected %h", dut_vec(), exp_v);
        end
        tick_cycle();
        exp_v = exp_q.pop_front(); vectors++;
        if (dut_vec() !== exp_v) begin
            miscompares++;
            $display("FAIL rollover_tick: got %h expected %h", dut_vec(), exp_v);
        end
        idle_cycle();
        exp_v = exp_q.pop_front(); vectors++;
        if (dut_vec() !== exp_v) begin
            miscompares++;
            $display("FAIL rollover_idle: got %h expected %h", dut_vec(), exp_v);
        end
    endtask

    task automatic test_leap();
        int tbl [6][7] = '{
            '{2024, 2, 28, 23, 59, 59, 3},
            '{2024, 2, 29, 12,  0,  0, 4},
            '{2000, 2, 29,  0,  0,  0, 2},
            '{2100, 3,  1,  0,  0,  0, 1},
            '{2023, 2, 29,  0,  0,  0, 3},
            '{2099, 2, 28, 23, 59, 59, 6}
        };
        for (int i = 0; i < 6; i++) begin
            drive_cycle(0, 1, 0, tbl[i][0], tbl[i][1], tbl[i][2], tbl[i][3],
                        tbl[i][4], tbl[i][5], tbl[i][6]);
            exp_v = exp_q.pop_front(); vectors++;
            if (dut_vec() !== exp_v) begin
                miscompares++;
                $display("FAIL leap_load[%0d]: got %h expected %h", i, dut_vec(), exp_v);
            end
            tick_cycle();
            exp_v = exp_q.pop_front(); vectors++;
            if (dut_vec() !== exp_v) begin
                miscompares++;
                $display("FAIL leap_tick[%0d]: got %h expected %h", i, dut_vec(), exp_v);
            end
        end
    endtask

    task automatic test_invalid_load();
        int tbl [8][7] = '{
            '{2024, 13, 1,  0,  0,  0, 0},
            '{2024,  5, 1, 24,  0,  0, 0},
            '{2024,  0, 1,  0,  0,  0, 0},
            '{2024,  4, 31, 0,  0,  0, 0},
            '{2024,  4, 0,  0,  0,  0, 0},
            '{2024,  4, 1,  0, 60,  0, 0},
            '{2024,  4, 1,  0,  0, 60, 0},
            '{1999,  4, 1,  0,  0,  0, 7}
        };
        drive_cycle(0, 1, 0, 2031, 7, 15, 8, 30, 45, 2);
        exp_v = exp_q.pop_front(); vectors++;
        if (dut_vec() !== exp_v) begin
            miscompares++;
            $display("FAIL invalid_setup: got %h expected %h", dut_vec(), exp_v);
        end
        for (int i = 0; i < 8; i++) begin
            drive_cycle(0, 1, 0, tbl[i][0], tbl[i][1], tbl[i][2], tbl[i][3],
                        tbl[i][4], tbl[i][5], tbl[i][6]);
            exp_v = exp_q.pop_front(); vectors++;
            if (dut_vec() !== exp_v) begin
                miscompares++;
                $display("FAIL invalid_load[%0d]: got %h expected %h", i, dut_vec(), exp_v);
            end
            idle_cycle();
            exp_v = exp_q.pop_front(); vectors++;
            if (dut_vec() !== exp_v) begin
                miscompares++;
                $display("FAIL invalid_err_drop[%0d]: got %h expected %h", i, dut_vec(), exp_v);
            end
        end
    endtask

    task automatic test_collision();
        drive_cycle(0, 1, 1, 2024, 5, 5, 12, 0, 0, 0);
        exp_v = exp_q.pop_front(); vectors++;
        if (dut_vec() !== exp_v) begin
            miscompares++;
            $display("FAIL collision_load_tick: got %h expected %h", dut_vec(), exp_v);
        end
        drive_cycle(0, 1, 1, 2024, 14, 5, 12, 0, 0, 0);
        exp_v = exp_q.pop_front(); vectors++;
        if (dut_vec() !== exp_v) begin
            miscompares++;
            $display("FAIL collision_bad_load_tick: got %h expected %h", dut_vec(), exp_v);
        end
        drive_cycle(1, 1, 1, 2030, 6, 6, 6, 6, 6, 6);
        exp_v = exp_q.pop_front(); vectors++;
        if (dut_vec() !== exp_v) begin
            miscompares++;
            $display("FAIL collision_reset_load: got %h expected %h", dut_vec(), exp_v);
        end
    endtask

    task automatic test_back_to_back();
        drive_cycle(0, 1, 0, 2099, 12, 31, 23, 59, 50, 4);
        exp_v = exp_q.pop_front(); vectors++;
        if (dut_vec() !== exp_v) begin
            miscompares++;
            $display("FAIL b2b_load: got %h expected %h", dut_vec(), exp_v);
        end
        for (int i = 0; i < 20; i++) begin
            tick_cycle();
            exp_v = exp_q.pop_front(); vectors++;
            if (dut_vec() !== exp_v) begin
                miscompares++;
                $display("FAIL b2b_tick[%0d]: got %h expected %h", i, dut_vec(), exp_v);
            end
        end
    endtask

    task automatic test_random();
        int r, y, mo, d, h, mi, s, w;
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                drive_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            end else if (r < 14) begin
                case ($urandom_range(0, 5))
                    0: y = 1999;
                    1: y = 2000;
                    2: y = 2024;
                    3: y = 2099;
                    4: y = 2100;
                    default: y = 2000 + int'($urandom_range(0, 99));
                endcase
                mo = int'($urandom_range(0, 13));
                d  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31))
                                                  : int'($urandom_range(27, 31));
                h  = int'($urandom_range(21, 24));
                mi = int'($urandom_range(57, 60));
                s  = int'($urandom_range(55, 60));
                w  = int'($urandom_range(0, 7));
                drive_cycle(0, 1, bit'($urandom_range(0, 1)), y, mo, d, h, mi, s, w);
            end else begin
                drive_cycle(0, 0, r < 80, 0, 0, 0, 0, 0, 0, 0);
            end
            exp_v = exp_q.pop_front(); vectors++;
            if (dut_vec() !== exp_v) begin
                miscompares++;
                $display("FAIL random[%0d]: got %h expected %h", i, dut_vec(), exp_v);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_cascade();
        test_year_rollover();
        test_leap();
        test_invalid_load();
        test_collision();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
